cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the ID -> Reg_File -> EXE datapath.
//  Fetches one instruction per pass from instruction memory (req/ack) and holds it in an instruction register (IR) that drives ID.
//  Gates the register-file write enable so the architectural state changes exactly once per instruction, in WRITEBACK.
//  Tracks PC, halt and fetch-timeout error status.
// PARAMETERS
//  ADDR_W     32             width of PC / imem_addr
//  PC_RESET   0              PC value after reset
//  PC_STEP    4              PC increment per retired instruction
//  TIMEOUT    16             max FETCH cycles without imem_ack before ERROR (>=1)
//  HALT_WORD  32'hFFFF_FFFF  instruction word that halts the core
// PORTS
//  clk           in   1       single clock, all state on posedge
//  rst           in   1       reset, synchronous, active-high
//  start         in   1       pulse: begin/resume execution from IDLE
//  stop          in   1       pulse: finish current instruction, then go IDLE
//  imem_req      out  1       fetch request, held high in FETCH
//  imem_addr     out  ADDR_W  fetch address (= PC)
//  imem_ack      in   1       instr_rdata valid this cycle
//  instr_rdata   in   32      fetched instruction word
//  instruction   out  32      IR contents, feeds ID
//  id_write_en   in   1       write_enable produced by ID for the IR instruction
//  rf_write_en   out  1       gated write_enable to Reg_File
//  busy          out  1       1 in FETCH/DECODE/EXECUTE/WRITEBACK
//  halted        out  1       1 in HALT state
//  error         out  1       1 in ERROR state (fetch timeout)
//  retired       out  32      count of instructions completed in WRITEBACK
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, PC=PC_RESET, IR=0, retired=0, run=0, timeout cnt=0;
//   all 1-bit outputs 0. Reset mid-fetch drops imem_req the next cycle; a late ack is ignored.
//  States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT, ERROR.
//  IDLE: start & !stop -> FETCH, run<=1. start & stop same cycle -> stay IDLE (stop wins).
//  FETCH: imem_req=1, imem_addr=PC. On imem_ack: IR<=instr_rdata, cnt<=0 -> DECODE.
//   Otherwise cnt++; when cnt reaches TIMEOUT-1 with no ack -> ERROR.
//   An ack on that same last cycle wins (-> DECODE). imem_ack outside FETCH is ignored.
//  DECODE (1 cycle): IR==HALT_WORD -> HALT (PC unchanged, not retired); else -> EXECUTE.
//  EXECUTE (1 cycle): ID/EXE settle on the IR; no state change -> WRITEBACK.
//  WRITEBACK (1 cycle): rf_write_en = id_write_en (combinational, this state only);
//   PC <= PC+PC_STEP (mod 2^ADDR_W, wraps silently); retired++ (wraps at 2^32).
//   Next: run ? FETCH : IDLE.
//  stop: sampled in any busy state, clears run; the in-flight instruction still completes WRITEBACK.
//   stop in IDLE/HALT/ERROR has no effect.
//  HALT, ERROR: terminal; only rst exits. start ignored. imem_req=0, rf_write_en=0.
//  Latency: one instruction = ack-cycle + 3 cycles, i.e. 4 cycles when imem_ack is in the first FETCH cycle.
//  rf_write_en is 0 in every state except WRITEBACK. instruction output is held stable from DECODE through WRITEBACK.
// TESTING
//  1 Reset then start; imem returns 0x0000_FFFF with 0-wait ack -> rf_write_en pulses 1 cycle
//    4 cycles later; PC 0->4; retired=1; R0=0x0000_FFFF.
//  2 Program MOV R0,#0xF / AND R0,R0,#0x6 / HALT_WORD -> retired=2; halted=1; PC=8;
//    imem_req low thereafter; start ignored.
//  3 imem_ack withheld -> error=1 after exactly TIMEOUT FETCH cycles; rf_write_en never asserted.
//    Repeat with ack on the last allowed cycle -> DECODE, no error.
//  4 stop asserted during EXECUTE -> instruction retires, state=IDLE, busy=0;
//    start resumes at the next PC. start+stop same cycle in IDLE -> stays IDLE.
//  5 rst asserted during FETCH and during WRITEBACK -> next cycle IDLE, PC=0, retired=0, outputs 0;
//    no reg write in the reset cycle.
//  6 PC_RESET=32'hFFFF_FFFC, one instruction retired -> PC wraps to 0.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch port: the sequencer drives req/addr and memory returns ack/rdata.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       instr_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  instr_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output instr_rdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer: one instruction per ack-cycle + 3 cycles.
// Backpressure comes from imem_ack: FETCH waits up to TIMEOUT cycles, then the core parks in ERROR.
module cpu_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] PC_RESET  = '0,
    parameter int                PC_STEP   = 4,
    parameter int                TIMEOUT   = 16,
    parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    cpu_sequencer_if.master        imem,
    output logic [31:0]            instruction,
    input  logic                   id_write_en,
    output logic                   rf_write_en,
    output logic                   busy,
    output logic                   halted,
    output logic                   error,
    output logic [31:0]            retired
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              run;
    logic              run_keep;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic              req_q;

    // A stop arriving in WRITEBACK itself still prevents the next fetch.
    assign run_keep = run && !stop;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start && !stop) state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ack)        state_nxt = S_DECODE;
                else if (cnt == CNT_LAST) state_nxt = S_ERROR;
            end
            S_DECODE:    state_nxt = (ir == HALT_WORD) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = run_keep ? S_FETCH : S_IDLE;
            default:     state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= PC_RESET;
            ir      <= '0;
            retired <= '0;
            run     <= 1'b0;
            cnt     <= '0;
            req_q   <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            error   <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_q  <= (state_nxt == S_FETCH);
            busy   <= (state_nxt inside {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK});
            halted <= (state_nxt == S_HALT);
            error  <= (state_nxt == S_ERROR);
            case (state)
                S_IDLE: if (start && !stop) run <= 1'b1;
                S_FETCH: begin
                    if (stop) run <= 1'b0;
                    if (imem.imem_ack) begin
                        ir  <= imem.instr_rdata;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DECODE, S_EXECUTE: if (stop) run <= 1'b0;
                S_WRITEBACK: begin
                    if (stop) run <= 1'b0;
                    pc      <= pc + PC_INC;
                    retired <= retired + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign instruction    = ir;
    // Gated by rst so an instruction caught in WRITEBACK by reset never writes.
    assign rf_write_en    = (state == S_WRITEBACK) && id_write_en && !rst;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: fetch/retire, halt, timeout, stop/resume, reset and PC wrap.
module tb_cpu_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        start, stop, id_write_en;
    logic [31:0] instruction, retired;
    logic        rf_write_en, busy, halted, error;
    logic        start2, stop2;
    logic [31:0] instruction2, retired2;
    logic        rf_write_en2, busy2, halted2, error2;

    logic        ack_auto, ack_man;
    logic [31:0] mem [0:7];
    int          checks, errors;

    cpu_sequencer_if #(.ADDR_W(32)) bus ();
    cpu_sequencer_if #(.ADDR_W(32)) bus2 ();

    assign bus.imem_ack     = ack_auto ? bus.imem_req : ack_man;
    assign bus.instr_rdata  = mem[bus.imem_addr[4:2]];
    assign bus2.imem_ack    = bus2.imem_req;
    assign bus2.instr_rdata = 32'h0000_0001;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .imem(bus.master),
        .instruction(instruction), .id_write_en(id_write_en), .rf_write_en(rf_write_en),
        .busy(busy), .halted(halted), .error(error), .retired(retired)
    );

    cpu_sequencer #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .imem(bus2.master),
        .instruction(instruction2), .id_write_en(id_write_en), .rf_write_en(rf_write_en2),
        .busy(busy2), .halted(halted2), .error(error2), .retired(retired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
        id_write_en = 1'b0; ack_auto = 1'b0; ack_man = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({bus.imem_req, busy, halted, error, rf_write_en} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {bus.imem_req, busy, halted, error, rf_write_en}); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.imem_addr); end
        checks++; if ({retired, instruction} !== 64'h0) begin errors++; $display("FAIL reset_ret_ir: got %h/%h want 0/0", retired, instruction); end
        checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc2: got %h want fffffffc", bus2.imem_addr); end
    endtask

    task automatic test_single();
        do_reset();
        mem[0] = 32'h0000_FFFF; mem[1] = HALT; ack_auto = 1'b1; id_write_en = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++; if ({bus.imem_req, busy, rf_write_en} !== 3'b110 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL t1_fetch: got req/busy/we=%b addr=%h want 110 addr 0", {bus.imem_req, busy, rf_write_en}, bus.imem_addr); end
        @(negedge clk);
        checks++; if (rf_write_en !== 1'b0 || instruction !== 32'h0000_FFFF) begin
            errors++; $display("FAIL t1_decode: got we=%b ir=%h want 0 0000ffff", rf_write_en, instruction); end
        @(negedge clk);
        checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL t1_exec_we: got %b want 0", rf_write_en); end
        @(negedge clk);
        checks++; if (rf_write_en !== 1'b1 || instruction !== 32'h0000_FFFF) begin
            errors++; $display("FAIL t1_wb: got we=%b ir=%h want 1 0000ffff", rf_write_en, instruction); end
        @(negedge clk);
        checks++; if (rf_write_en !== 1'b0 || retired !== 32'd1 || bus.imem_addr !== 32'h4) begin
            errors++; $display("FAIL t1_after: got we=%b ret=%0d pc=%h want 0 1 4", rf_write_en, retired, bus.imem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (halted !== 1'b1 || retired !== 32'd1 || bus.imem_addr !== 32'h4) begin
            errors++; $display("FAIL t1_halt: got halted=%b ret=%0d pc=%h want 1 1 4", halted, retired, bus.imem_addr); end
    endtask

    task automatic test_program();
        int cycles, pulses, req_seen;
        do_reset();
        mem[0] = 32'hE3A0_000F; mem[1] = 32'hE200_0006; mem[2] = HALT;
        ack_auto = 1'b1; id_write_en = 1'b1;
        cycles = 0; pulses = 0;
        start = 1'b1;
        while (!halted && cycles < 50) begin
            @(negedge clk); start = 1'b0; cycles++;
            if (rf_write_en) pulses++;
        end
        checks++; if (cycles !== 11) begin errors++; $display("FAIL t2_cycles: got %0d want 11", cycles); end
        checks++; if (pulses !== 2 || retired !== 32'd2) begin errors++; $display("FAIL t2_retired: got pulses=%0d ret=%0d want 2 2", pulses, retired); end
        checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL t2_pc: got %h want 8", bus.imem_addr); end
        req_seen = 0;
        start = 1'b1;
        repeat (4) begin
            @(negedge clk); start = 1'b0;
            if (bus.imem_req || busy) req_seen++;
        end
        checks++; if (req_seen !== 0 || halted !== 1'b1) begin errors++; $display("FAIL t2_start_ignored: got active=%0d halted=%b want 0 1", req_seen, halted); end
    endtask

    task automatic test_timeout();
        int cycles, fetches, we_seen;
        do_reset();
        id_write_en = 1'b1;
        cycles = 0; fetches = 0; we_seen = 0;
        start = 1'b1;
        while (!error && cycles < 40) begin
            @(negedge clk); start = 1'b0; cycles++;
            if (bus.imem_req) fetches++;
            if (rf_write_en) we_seen++;
        end
        checks++; if (error !== 1'b1 || fetches !== 16 || cycles !== 17) begin
            errors++; $display("FAIL t3_timeout: got error=%b fetches=%0d cycles=%0d want 1 16 17", error, fetches, cycles); end
        checks++; if (we_seen !== 0 || bus.imem_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL t3_error_state: got we=%0d req=%b busy=%b want 0 0 0", we_seen, bus.imem_req, busy); end

        do_reset();
        mem[0] = 32'h1234_5678;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL t3_last_fetch: got req=%b error=%b want 1 0", bus.imem_req, error); end
        ack_man = 1'b1;
        @(negedge clk); ack_man = 1'b0;
        checks++; if (busy !== 1'b1 || error !== 1'b0 || bus.imem_req !== 1'b0 || instruction !== 32'h1234_5678) begin
            errors++; $display("FAIL t3_late_ack: got busy=%b err=%b req=%b ir=%h want 1 0 0 12345678", busy, error, bus.imem_req, instruction); end
    endtask

    task automatic test_stop();
        int cycles;
        do_reset();
        mem[0] = 32'hA000_0001; mem[1] = 32'hA000_0002; mem[2] = HALT;
        ack_auto = 1'b1; id_write_en = 1'b1;
        start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL t4_start_stop: got busy=%b req=%b want 0 0", busy, bus.imem_req); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL t4_wb: got we=%b want 1", rf_write_en); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || retired !== 32'd1 || bus.imem_addr !== 32'h4 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL t4_idle: got busy=%b ret=%0d pc=%h req=%b want 0 1 4 0", busy, retired, bus.imem_addr, bus.imem_req); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
            errors++; $display("FAIL t4_resume: got req=%b pc=%h want 1 4", bus.imem_req, bus.imem_addr); end
        cycles = 0;
        while (!halted && cycles < 30) begin @(negedge clk); cycles++; end
        checks++; if (halted !== 1'b1 || retired !== 32'd2 || bus.imem_addr !== 32'h8) begin
            errors++; $display("FAIL t4_finish: got halted=%b ret=%0d pc=%h want 1 2 8", halted, retired, bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem[0] = 32'hB000_0001; mem[1] = 32'hB000_0002;
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL t5_in_fetch: got req=%b want 1", bus.imem_req); end
        rst = 1'b1; @(negedge clk); rst = 1'b0; ack_man = 1'b1;
        checks++; if ({bus.imem_req, busy} !== 2'b00 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL t5_fetch_rst: got req/busy=%b pc=%h want 00 0", {bus.imem_req, busy}, bus.imem_addr); end
        @(negedge clk); ack_man = 1'b0;
        checks++; if (busy !== 1'b0 || instruction !== 32'h0) begin errors++; $display("FAIL t5_late_ack: got busy=%b ir=%h want 0 0", busy, instruction); end

        ack_auto = 1'b1; id_write_en = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (rf_write_en !== 1'b1 || retired !== 32'd1) begin errors++; $display("FAIL t5_in_wb: got we=%b ret=%0d want 1 1", rf_write_en, retired); end
        rst = 1'b1; #1;
        checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL t5_wb_gate: got we=%b want 0", rf_write_en); end
        @(negedge clk); rst = 1'b0;
        checks++; if ({bus.imem_req, busy, halted, error, rf_write_en} !== 5'b0 || bus.imem_addr !== 32'h0 || retired !== 32'h0 || instruction !== 32'h0) begin
            errors++; $display("FAIL t5_wb_rst: got flags=%b pc=%h ret=%0d ir=%h want 00000 0 0 0",
                {bus.imem_req, busy, halted, error, rf_write_en}, bus.imem_addr, retired, instruction); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC || bus2.imem_req !== 1'b1) begin
            errors++; $display("FAIL t6_fetch: got pc=%h req=%b want fffffffc 1", bus2.imem_addr, bus2.imem_req); end
        repeat (2) @(negedge clk);
        stop2 = 1'b1; @(negedge clk); stop2 = 1'b0;
        @(negedge clk);
        checks++; if (bus2.imem_addr !== 32'h0 || retired2 !== 32'd1 || busy2 !== 1'b0) begin
            errors++; $display("FAIL t6_wrap: got pc=%h ret=%0d busy=%b want 0 1 0", bus2.imem_addr, retired2, busy2); end
    endtask

    initial begin
        checks = 0; errors = 0;
        for (int i = 0; i < 8; i++) mem[i] = HALT;
        test_reset();
        test_single();
        test_program();
        test_timeout();
        test_stop();
        test_reset_mid();
        test_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
